// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU: operation codes and sequencer states.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SLT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/one_bit_ALU.sv
// One-bit ALU slice: AND/OR/full-add of a and (b ^ binvert), plus ripple carry.
// Purely combinational; SLT yields the sum bit and is resolved by the sequencer.
module one_bit_ALU
  import alu_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic binvert,
  input  logic carry_in,
  input  op_e  operation,
  output logic result,
  output logic carry_out
);

  logic b_eff;
  logic sum;

  assign b_eff     = b ^ binvert;
  assign sum       = a ^ b_eff ^ carry_in;
  assign carry_out = (a & b_eff) | (a & carry_in) | (b_eff & carry_in);

  always_comb begin
    result = sum;
    case (operation)
      OP_AND:  result = a & b_eff;
      OP_OR:   result = a | b_eff;
      default: result = sum;
    endcase
  end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU: one slice reused LSB-first for WIDTH cycles; result valid WIDTH+1 cycles after accept.
// Single request in flight; result and flags held in DONE until res_ready, start_ready low while busy.
module serial_alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             binvert,
  input  logic [1:0]       operation,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             res_valid,
  input  logic             res_ready
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               binv_q, binv_d;
  op_e                op_q, op_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_out_q, carry_out_d;
  logic               overflow_q, overflow_d;

  logic slice_res;
  logic slice_cout;
  logic last_bit;

  // Operands are shifted right each RUN cycle so the slice always sees bit 0.
  one_bit_ALU u_slice (
    .a         (a_q[0]),
    .b         (b_q[0]),
    .binvert   (binv_q),
    .carry_in  (carry_q),
    .operation (op_q),
    .result    (slice_res),
    .carry_out (slice_cout)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    binv_d      = binv_q;
    op_d        = op_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    start_ready = 1'b0;
    res_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          a_d     = a;
          b_d     = b;
          binv_d  = binvert;
          op_d    = op_e'(operation);
          carry_d = binvert;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d             = a_q >> 1;
        b_d             = b_q >> 1;
        carry_d         = slice_cout;
        cnt_d           = cnt_q + CNT_W'(1);
        result_d        = result_q >> 1;
        result_d[WIDTH-1] = slice_res;
        if (last_bit) begin
          // carry_q is the carry into the MSB slice here.
          carry_out_d = slice_cout;
          overflow_d  = carry_q ^ slice_cout;
          if (op_q == OP_SLT) begin
            result_d    = '0;
            result_d[0] = slice_res ^ carry_q ^ slice_cout;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      binv_q      <= 1'b0;
      op_q        <= OP_AND;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      binv_q      <= binv_d;
      op_q        <= op_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = (result_q == '0);

endmodule

// File: doc/serial_alu_seq.md
SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits (legal range 1..32).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-004 SHALL have port start_valid, input, 1 bit, request carries a valid operation.
REQ-005 SHALL have port start_ready, output, 1 bit, block can accept a request.
REQ-006 SHALL have port a, input, WIDTH bits, operand A.
REQ-007 SHALL have port b, input, WIDTH bits, operand B.
REQ-008 SHALL have port binvert, input, 1 bit, invert B; it is also the carry-in of bit 0.
REQ-009 SHALL have port operation, input, 2 bits: 00 AND, 01 OR, 10 ADD, 11 SLT.
REQ-010 SHALL have port result, output, WIDTH bits, the registered result word.
REQ-011 SHALL have port carry_out, output, 1 bit, carry out of the MSB slice.
REQ-012 SHALL have port overflow, output, 1 bit, signed overflow (carry into MSB XOR carry out of MSB).
REQ-013 SHALL have port zero, output, 1 bit, high when result equals 0.
REQ-014 SHALL have port res_valid, output, 1 bit, result and flags are valid.
REQ-015 SHALL have port res_ready, input, 1 bit, consumer accepts the result.

Function
REQ-016 SHALL implement the states IDLE, RUN and DONE.
REQ-017 IDLE: start_ready=1; on start_valid, SHALL latch a, b, binvert and operation, load carry from binvert, clear the bit counter, and go to RUN.
REQ-018 RUN: SHALL process one bit per cycle, LSB first, through a single 1-bit slice with inputs a[i], b[i]^binvert and the carry register; SHALL shift the slice output into result and register the slice carry.
REQ-019 RUN SHALL last exactly WIDTH cycles, then go to DONE; accept-to-res_valid latency is WIDTH+1 cycles.
REQ-020 Slice result per operation: AND a&b'; OR a|b'; ADD and SLT give the sum bit. b' is b XOR binvert.
REQ-021 At the MSB cycle, SHALL capture the carry-in of the MSB slice to form overflow.
REQ-022 SLT: SHALL set the final result to {WIDTH-1 zeros, MSB sum XOR overflow}. Meaningful only with binvert=1.
REQ-023 For AND and OR, carry_out and overflow SHALL still reflect the adder chain of the latched operands.
REQ-024 DONE: res_valid=1 and result and flags held stable until res_ready=1; then go to IDLE.
REQ-025 start_ready SHALL be 0 in RUN and DONE. start_valid in those states SHALL be ignored, and latched operands SHALL be unaffected by input changes.
REQ-026 DONE with res_ready=1 and start_valid=1 in the same cycle: the result retires, and the new request is accepted at the next cycle in IDLE.
REQ-027 The bit counter SHALL be $clog2(WIDTH+1) bits wide. WIDTH=1 SHALL produce one RUN cycle, with the MSB equal to the LSB.

Reset
REQ-028 rst SHALL force IDLE immediately, including mid-RUN or mid-DONE. The in-flight operation is discarded.
REQ-029 Reset values: result=0, carry_out=0, overflow=0, zero=1, res_valid=0, start_ready=1 after release.

Structure
REQ-030 Shared package alu_pkg SHALL hold the operation encodings (OP_AND, OP_OR, OP_ADD, OP_SLT) and the state enumeration.
REQ-031 The per-bit datapath SHALL instantiate the team's existing one_bit_ALU slice, which is the only sub-module.

Verification (WIDTH=8)
REQ-032 ADD a=0x7F, b=0x01, binvert=0 -> result 0x80, overflow=1, carry_out=0, zero=0, res_valid 9 cycles after accept.
REQ-033 SUB a=0x05, b=0x05, binvert=1, op=10 -> result 0x00, zero=1, carry_out=1, overflow=0.
REQ-034 AND a=0xF0, b=0x3C -> result 0x30; OR with the same operands -> 0xFC.
REQ-035 SLT a=0xFE, b=0x01, binvert=1 -> result 0x01; SLT a=0x01, b=0xFE -> result 0x00.
REQ-036 Backpressure: hold res_ready=0 for 5 cycles in DONE while toggling a, b and start_valid -> res_valid stays 1, result stable, start_ready=0, no second accept.
REQ-037 Assert rst in the 3rd RUN cycle -> the same cycle gives res_valid=0, result=0, IDLE; a following ADD 0x01+0x01 -> 0x02.
